// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared types and constants for the program loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int LOADER_WIDTH         = 16;
    localparam int LOADER_COUNTER_WIDTH = 8;

    function automatic int byte_idx_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

    localparam int BYTES_PER_WORD = LOADER_WIDTH / 8;
    localparam int BYTE_IDX_W     = byte_idx_width(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
// ============================================================================
// Module : word_assembler
// Brief  : Packs little-endian bytes into a WIDTH-bit word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler
    import loader_pkg::*;
#(
    parameter int WIDTH = LOADER_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [7:0]       byte_i,
    output logic             word_complete_o,
    output logic [WIDTH-1:0] word_o
);

    localparam int                BPW      = WIDTH / 8;
    localparam int                IDX_W    = byte_idx_width(BPW);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] word_q, word_d;

    assign word_complete_o = enable_i && (idx_q == LAST_IDX);
    assign word_o          = word_q;

    // Unwritten byte lanes keep whatever they held from the previous word.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (enable_i) begin
            for (int k = 0; k < BPW; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    word_d[8*k +: 8] = byte_i;
                end
            end
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Byte-stream loader writing WIDTH-bit words into instruction memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter int WIDTH         = LOADER_WIDTH,
    parameter int COUNTER_WIDTH = LOADER_COUNTER_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     wr_en,
    output logic [COUNTER_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               words_loaded
);

    loader_state_t            state_q, state_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               words_q, words_d;
    logic [COUNTER_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               words_inc;

    logic w_handshake;
    logic w_asm_clear;
    logic w_asm_enable;
    logic w_word_complete;

    // Ready is a pure decode of the state register, never of rx_valid.
    assign rx_ready     = (state_q == LEN) || (state_q == DATA);
    assign busy         = rx_ready || (state_q == WRITE);
    assign cpu_hold     = busy;
    assign wr_en        = (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign wr_addr      = addr_q;
    assign words_loaded = words_q;
    assign w_handshake  = rx_valid && rx_ready;
    assign words_inc    = words_q + 8'd1;

    word_assembler #(
        .WIDTH (WIDTH)
    ) u_word_assembler (
        .clock           (clock),
        .reset           (reset),
        .clear_i         (w_asm_clear),
        .enable_i        (w_asm_enable),
        .byte_i          (rx_data),
        .word_complete_o (w_word_complete),
        .word_o          (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        words_d      = words_q;
        addr_d       = addr_q;
        w_asm_clear  = 1'b0;
        w_asm_enable = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LEN;
                    words_d = '0;
                    addr_d  = '0;
                end
            end
            LEN: begin
                if (w_handshake) begin
                    len_d       = rx_data;
                    w_asm_clear = 1'b1;
                    state_d     = (rx_data == 8'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                w_asm_enable = w_handshake;
                if (w_word_complete) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_inc;
                addr_d  = addr_q + COUNTER_WIDTH'(1);
                state_d = (words_inc == len_q) ? DONE : DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            addr_q  <= addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module : tb_program_loader
// Brief  : Directed self-checking bench for program_loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [7:0]  words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  wq_addr [0:15];
    logic [15:0] wq_data [0:15];
    int          wq_n = 0;

    program_loader #(
        .WIDTH         (16),
        .COUNTER_WIDTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Records every memory write seen, sampled mid-cycle.
    always @(negedge clock) begin
        if (wr_en && wq_n < 16) begin
            wq_addr[wq_n] = wr_addr;
            wq_data[wq_n] = wr_data;
            wq_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("send_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 50 && !done; i++) @(negedge clock);
        check(tag, {31'd0, done}, 32'd1);
    endtask

    logic       t3_valid [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t3_data  [0:5] = '{8'h78, 8'hEE, 8'hEE, 8'h56, 8'hEE, 8'h99};
    logic       t3_rdy   [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_addr",  {24'd0, wr_addr}, 32'd0);
        check("rst_data",  {16'd0, wr_data}, 32'd0);
        check("rst_words", {24'd0, words_loaded}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Basic two-word load
        wq_n = 0;
        @(negedge clock);
        check("t1_idle_ready", {31'd0, rx_ready}, 32'd0);
        pulse_start();
        check("t1_len_hold",  {31'd0, cpu_hold}, 32'd1);
        check("t1_len_busy",  {31'd0, busy}, 32'd1);
        check("t1_len_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        check("t1_w0_en",    {31'd0, wr_en}, 32'd1);
        check("t1_w0_addr",  {24'd0, wr_addr}, 32'd0);
        check("t1_w0_data",  {16'd0, wr_data}, 32'h1234);
        check("t1_w0_ready", {31'd0, rx_ready}, 32'd0);
        send_byte(8'hCD);
        send_byte(8'hAB);
        check("t1_w1_en",   {31'd0, wr_en}, 32'd1);
        check("t1_w1_addr", {24'd0, wr_addr}, 32'd1);
        check("t1_w1_data", {16'd0, wr_data}, 32'hABCD);
        check("t1_w1_hold", {31'd0, cpu_hold}, 32'd1);
        wait_done("t1_done");
        check("t1_words", {24'd0, words_loaded}, 32'd2);
        check("t1_hold",  {31'd0, cpu_hold}, 32'd0);
        check("t1_addr",  {24'd0, wr_addr}, 32'd2);
        check("t1_nwr",   wq_n, 32'd2);
        check("t1_q0",    {16'd0, wq_addr[0], wq_data[0]}, 32'h0000_1234);
        check("t1_q1",    {16'd0, wq_addr[1], wq_data[1]}, 32'h0001_ABCD);

        // Zero-length load
        wq_n = 0;
        pulse_start();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        send_byte(8'h00);
        check("t2_done",  {31'd0, done}, 32'd1);
        check("t2_words", {24'd0, words_loaded}, 32'd0);
        check("t2_addr",  {24'd0, wr_addr}, 32'd0);
        check("t2_hold",  {31'd0, cpu_hold}, 32'd0);
        check("t2_nwr",   wq_n, 32'd0);

        // Back-pressure and gaps
        wq_n = 0;
        pulse_start();
        send_byte(8'h01);
        for (int i = 0; i < 6; i++) begin
            rx_valid = t3_valid[i];
            rx_data  = t3_data[i];
            check("t3_ready", {31'd0, rx_ready}, {31'd0, t3_rdy[i]});
            if (i == 4) begin
                check("t3_wr_en", {31'd0, wr_en}, 32'd1);
                check("t3_data",  {16'd0, wr_data}, 32'h5678);
            end
            @(negedge clock);
        end
        rx_valid = 1'b0;
        check("t3_done",  {31'd0, done}, 32'd1);
        check("t3_words", {24'd0, words_loaded}, 32'd1);
        check("t3_addr",  {24'd0, wr_addr}, 32'd1);
        check("t3_nwr",   wq_n, 32'd1);
        check("t3_q0",    {16'd0, wq_addr[0], wq_data[0]}, 32'h0000_5678);

        // Start ignored while busy
        wq_n = 0;
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h11);
        pulse_start();
        check("t4_busy",  {31'd0, busy}, 32'd1);
        check("t4_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        wait_done("t4_done");
        check("t4_words", {24'd0, words_loaded}, 32'd3);
        check("t4_nwr",   wq_n, 32'd3);
        check("t4_q0",    {16'd0, wq_addr[0], wq_data[0]}, 32'h0000_2211);
        check("t4_q1",    {16'd0, wq_addr[1], wq_data[1]}, 32'h0001_4433);
        check("t4_q2",    {16'd0, wq_addr[2], wq_data[2]}, 32'h0002_6655);

        // Asynchronous reset mid-load
        wq_n = 0;
        pulse_start();
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clock);
        send_byte(8'hCC);
        check("t5_pre_hold", {31'd0, cpu_hold}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_hold",  {31'd0, cpu_hold}, 32'd0);
        check("t5_busy",  {31'd0, busy}, 32'd0);
        check("t5_ready", {31'd0, rx_ready}, 32'd0);
        check("t5_addr",  {24'd0, wr_addr}, 32'd0);
        check("t5_data",  {16'd0, wr_data}, 32'd0);
        check("t5_words", {24'd0, words_loaded}, 32'd0);
        check("t5_done",  {31'd0, done}, 32'd0);
        check("t5_nwr_pre", wq_n, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        wq_n  = 0;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_done("t5_reload_done");
        check("t5_nwr", wq_n, 32'd1);
        check("t5_q0",  {16'd0, wq_addr[0], wq_data[0]}, 32'h0000_0201);

        // Reload after DONE
        wq_n = 0;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h22);
        wait_done("t6_first_done");
        check("t6_first_words", {24'd0, words_loaded}, 32'd2);
        wq_n = 0;
        pulse_start();
        check("t6_done_clr", {31'd0, done}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h55);
        wait_done("t6_done");
        check("t6_words", {24'd0, words_loaded}, 32'd1);
        check("t6_nwr",   wq_n, 32'd1);
        check("t6_q0",    {16'd0, wq_addr[0], wq_data[0]}, 32'h0000_5555);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory. It receives a byte stream over a valid/ready handshake and packs the bytes into WIDTH-bit instruction words.
- Each word is written into the instruction memory at sequential addresses. The CPU fetch path (program counter and memory read) is the reader of that memory.
- While loading, the block drives cpu_hold, which the top level ORs into the CPU reset. The CPU therefore starts at address 0 only after the program is in place.

Parameters:
- WIDTH, 16, instruction word width in bits; must be a multiple of 8.
- COUNTER_WIDTH, 8, memory address width; must be >= 8.
- BYTES_PER_WORD, WIDTH/8, derived; not overridable.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  COUNTER_WIDTH  memory write address.
- wr_data  output  WIDTH  memory write data.
- cpu_hold  output  1  hold the CPU in reset while high.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed; sticky.
- words_loaded  output  8  words written in the current or last load.

Behaviour:
- Reset values: state IDLE; rx_ready, wr_en, cpu_hold, busy and done all 0; wr_addr, wr_data and words_loaded all 0; byte index 0.
- Byte transfer: a byte transfers on a rising edge with rx_valid && rx_ready. rx_ready is a registered state decode and never depends combinationally on rx_valid.
- States: IDLE, LEN, DATA, WRITE, DONE.
- IDLE:
  - rx_ready = 0.
  - On start, go to LEN. Clear words_loaded and done, and set wr_addr to 0.
- LEN:
  - rx_ready = 1; cpu_hold = 1; busy = 1.
  - The first accepted byte is the word count N (0..255).
  - If N = 0, go to DONE. Otherwise go to DATA with byte index 0.
- DATA:
  - rx_ready = 1; cpu_hold = 1; busy = 1.
  - Bytes are little-endian: byte k goes into wr_data[8k+7:8k].
  - When byte BYTES_PER_WORD-1 is accepted, go to WRITE.
  - Bytes not yet received keep their previous value. There are no stale-bit guarantees until the word completes.
- WRITE (exactly 1 cycle):
  - rx_ready = 0; wr_en = 1, with wr_addr and wr_data stable and registered.
  - Latency: wr_en asserts on the cycle immediately after the final byte of a word is accepted.
  - On exit, words_loaded and wr_addr increment.
  - If the incremented words_loaded equals N, go to DONE; else go to DATA with byte index 0.
- DONE:
  - done = 1, cpu_hold = 0, busy = 0, rx_ready = 0.
  - wr_addr holds N, i.e. one past the last written address.
  - start re-enters LEN (done clears on that edge).
- start during LEN, DATA or WRITE is ignored.
- Stall: rx_valid low in LEN or DATA leaves all state unchanged indefinitely. There is no timeout.
- Reset mid-load: returns to IDLE immediately and cpu_hold drops. Memory words already written stay; no rollback.
- Address range: with COUNTER_WIDTH >= 8, N <= 255 always fits, so wr_addr never wraps within a load.
- wr_en is never asserted outside WRITE.

Decomposition:
- Package loader_pkg:
  - state enum loader_state_t {IDLE, LEN, DATA, WRITE, DONE};
  - constant BYTES_PER_WORD;
  - byte index width localparam $clog2(BYTES_PER_WORD), minimum 1.
- The block shares the WIDTH and COUNTER_WIDTH values from parameters.h.
- One sub-module is natural: word_assembler. It holds the byte index and shift/insert logic and outputs word_complete and the WIDTH-bit word. It has a clear input and an enable driven by the handshake.
- The FSM, address counter and word counter stay in program_loader.

Test Plan:
1. Basic load: reset, start, send 0x02, 0x34, 0x12, 0xCD, 0xAB with rx_valid held high. Required:
   - wr_en pulses twice: addr 0 with data 0x1234, then addr 1 with data 0xABCD;
   - done = 1, words_loaded = 2, cpu_hold high from the LEN entry edge until the DONE entry edge.
2. Zero length: start, send 0x00. Required: no wr_en, DONE on the next edge, done = 1, words_loaded = 0, wr_addr = 0.
3. Back-pressure and gaps: N = 1 with rx_valid toggled 1-0-0-1-0-1. Required:
   - only handshaked bytes are consumed;
   - rx_ready = 0 during WRITE;
   - single write of the correct word;
   - no byte is accepted while rx_ready = 0.
4. Start ignored while busy: pulse start during DATA of an N = 3 load. Required: the load continues unchanged and three writes go to addresses 0, 1, 2.
5. Reset mid-load: assert reset asynchronously, between clock edges, after the first word is written in an N = 4 load. Required:
   - all outputs go to reset values without waiting for a clock edge;
   - a subsequent start plus N = 1 writes to addr 0.
6. Reload after DONE: complete N = 2, then start again with N = 1 and data 0x5555. Required: done drops, there is one write to addr 0, then done = 1 and words_loaded = 1.
